// File: rtl/clkdiv_sched.sv
// Programmable clock divider with a boundary-synchronised ratio scheduler.
// Optional CLKDIV_SCHED_SWCNT_EN adds a saturating ratio-switch counter output.
module clkdiv_sched #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
`ifdef CLKDIV_SCHED_SWCNT_EN
    output logic [7:0]       switch_cnt,
`endif
    output logic [CNT_W-1:0] cur_div
);

    // state   | meaning
    // STOPPED | output held low, cnt held at 0, waiting for run
    // RUN     | cnt cycles 0..cur_div-1, one output period per wrap
    typedef enum logic {STOPPED, RUN} state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_div_nxt;
    logic             pend, pend_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic             err_nxt, tick_nxt, clk_out_nxt;
    logic             xfer, legal, boundary;

    assign xfer     = cfg_valid && cfg_ready;
    assign legal    = (cfg_div >= CNT_W'(2));
    assign boundary = (cnt == cur_div - CNT_W'(1));

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_div_nxt  = cur_div;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;
        err_nxt      = xfer && !legal;
        tick_nxt     = 1'b0;
        clk_out_nxt  = 1'b0;

        case (state)
            STOPPED: begin
                if (xfer && legal)
                    cur_div_nxt = cfg_div;
                if (run) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (boundary) begin
                    // A ratio arriving exactly on the boundary skips the pending slot.
                    if (pend) begin
                        cur_div_nxt = pend_div;
                        pend_nxt    = 1'b0;
                    end else if (xfer && legal) begin
                        cur_div_nxt = cfg_div;
                    end
                    cnt_nxt = '0;
                    if (!run)
                        state_nxt = STOPPED;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (xfer && legal) begin
                        pend_nxt     = 1'b1;
                        pend_div_nxt = cfg_div;
                    end
                end
            end
            default: state_nxt = STOPPED;
        endcase

        // Outputs are registered, so derive them from the next-cycle counter and ratio.
        if (state_nxt == RUN) begin
            clk_out_nxt = (cnt_nxt < (cur_div_nxt >> 1));
            tick_nxt    = (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= STOPPED;
            cnt       <= '0;
            cur_div   <= DEF_DIV_V;
            pend      <= 1'b0;
            pend_div  <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_div   <= cur_div_nxt;
            pend      <= pend_nxt;
            pend_div  <= pend_div_nxt;
            cfg_ready <= !pend_nxt;
            cfg_err   <= err_nxt;
            clk_out   <= clk_out_nxt;
            tick      <= tick_nxt;
            busy      <= (state_nxt == RUN);
        end
    end

`ifdef CLKDIV_SCHED_SWCNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            switch_cnt <= '0;
        else if ((cur_div_nxt != cur_div) && (switch_cnt != 8'hFF))
            switch_cnt <= switch_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed vector bench for clkdiv_sched (CNT_W=8, DEF_DIV=4).
// Define CLKDIV_SCHED_SWCNT_EN to also check the switch counter.
module tb_clkdiv_sched;

    logic       clk = 1'b0;
    logic       rst, run, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, cfg_err, clk_out, tick, busy;
    logic [7:0] cur_div;
`ifdef CLKDIV_SCHED_SWCNT_EN
    logic [7:0] switch_cnt;
`endif

    always #5 clk = ~clk;

    clkdiv_sched #(.CNT_W(8), .DEF_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .busy(busy),
`ifdef CLKDIV_SCHED_SWCNT_EN
        .switch_cnt(switch_cnt),
`endif
        .cur_div(cur_div)
    );

    typedef struct {
        logic       rst, run, vld;
        logic [7:0] div;
        logic       e_clk, e_tick, e_busy, e_rdy, e_err;
        logic [7:0] e_cur, e_sw;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic rn, input logic v, input logic [7:0] d,
                       input logic c, input logic t, input logic b, input logic rd,
                       input logic e, input logic [7:0] cu, input logic [7:0] sw);
        vec_t x;
        x = '{r, rn, v, d, c, t, b, rd, e, cu, sw};
        vq.push_back(x);
    endtask

    task automatic check(input string name, input vec_t x);
        logic [7:0] sw_act;
`ifdef CLKDIV_SCHED_SWCNT_EN
        sw_act = switch_cnt;
`else
        sw_act = x.e_sw;
`endif
        n_vec++;
        if (clk_out !== x.e_clk || tick !== x.e_tick || busy !== x.e_busy ||
            cfg_ready !== x.e_rdy || cfg_err !== x.e_err || cur_div !== x.e_cur ||
            sw_act !== x.e_sw) begin
            n_err++;
            $display("FAIL %s got clk_out=%b tick=%b busy=%b rdy=%b err=%b cur=%0d sw=%0d want clk_out=%b tick=%b busy=%b rdy=%b err=%b cur=%0d sw=%0d",
                     name, clk_out, tick, busy, cfg_ready, cfg_err, cur_div, sw_act,
                     x.e_clk, x.e_tick, x.e_busy, x.e_rdy, x.e_err, x.e_cur, x.e_sw);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t x;
        int   per, hi, waited;

        //   rst run vld div  clk tck bsy rdy err cur sw
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 4, 0);
        add(0, 1, 0, 0,   0, 0, 0, 1, 0, 4, 0);
        // default ratio 4: 1,1,0,0
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 4, 0);
        // mid-period write of 6 at cnt=1
        add(1, 1, 1, 6,   0, 0, 1, 0, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 0, 0, 4, 0);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 6, 1);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 6, 1);
        // back to 4 via pending slot
        add(1, 1, 1, 4,   1, 0, 1, 0, 0, 6, 1);
        add(1, 1, 0, 0,   1, 0, 1, 0, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 0, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 0, 0, 6, 1);
        add(1, 1, 0, 0,   0, 0, 1, 0, 0, 6, 1);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 2);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 4, 2);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 2);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 2);
        // boundary-coincident write of 2
        add(1, 1, 1, 2,   1, 1, 1, 1, 0, 2, 3);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 2, 3);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 2, 3);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 2, 3);
        // illegal ratios 1 and 0
        add(1, 1, 1, 1,   1, 1, 1, 1, 1, 2, 3);
        add(1, 1, 1, 0,   0, 0, 1, 1, 1, 2, 3);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 2, 3);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 2, 3);
        // direct apply of 4, then drop run at cnt=1
        add(1, 1, 1, 4,   1, 1, 1, 1, 0, 4, 4);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 4, 4);
        add(1, 0, 0, 0,   0, 0, 1, 1, 0, 4, 4);
        add(1, 0, 0, 0,   0, 0, 1, 1, 0, 4, 4);
        add(1, 0, 0, 0,   0, 0, 0, 1, 0, 4, 4);
        add(1, 0, 0, 0,   0, 0, 0, 1, 0, 4, 4);
        // odd ratio 5 written while stopped: 1,1,0,0,0
        add(1, 0, 1, 5,   0, 0, 0, 1, 0, 5, 5);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 5, 5);
        add(1, 1, 0, 0,   1, 0, 1, 1, 0, 5, 5);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 5, 5);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 5, 5);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 5, 5);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 5, 5);
        // pend 7, then reset mid-period drops it
        add(1, 1, 1, 7,   1, 0, 1, 0, 0, 5, 5);
        add(0, 1, 0, 0,   0, 0, 0, 1, 0, 4, 0);
        add(1, 0, 0, 0,   0, 0, 0, 1, 0, 4, 0);
        // run glitch inside a period is ignored
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 0);
        add(1, 0, 0, 0,   1, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   0, 0, 1, 1, 0, 4, 0);
        add(1, 1, 0, 0,   1, 1, 1, 1, 0, 4, 0);

        rst = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        for (int i = 0; i < vq.size(); i++) begin
            x = vq[i];
            rst = x.rst; run = x.run; cfg_valid = x.vld; cfg_div = x.div;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), x);
        end

        // ratio 3 via pending slot: measure one full period after it takes effect
        run = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd3;
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_div = '0;
        waited = 0;
        while (!(tick && cur_div == 8'd3) && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk_int("n3_apply_wait_ok", (waited < 10) ? 1 : 0, 1);
        per = 0; hi = 0;
        do begin
            if (clk_out) hi++;
            per++;
            @(posedge clk); #1;
        end while (!tick && per < 10);
        chk_int("n3_period", per, 3);
        chk_int("n3_high", hi, 1);
        chk_int("n3_cur_div", int'(cur_div), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clkdiv_sched.md
Name: clkdiv_sched

Overview:
- Programmable, run-controlled clock divider with a safe reconfiguration scheduler.
- Generates a divided clock-like output (clk_out) and a one-cycle period-start strobe (tick) from clk.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a period boundary, so no runt or stretched pulses are produced.
- Replaces the fixed power-of-two taps where software-selected rates are needed.

Parameters:
- CNT_W, 8: width of the divide value and the period counter.
- DEF_DIV, 4: divide ratio loaded at reset; must be in the range 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- run  in  1  level; 1 = generate output, 0 = stop at the end of the current period
- cfg_valid  in  1  new divide ratio offered
- cfg_div  in  CNT_W  requested ratio N (output period = N clk cycles)
- cfg_ready  out  1  block can accept a ratio
- cfg_err  out  1  one-cycle pulse: accepted ratio was illegal and was discarded
- clk_out  out  1  divided output
- tick  out  1  one-cycle pulse at the first cycle of every output period
- busy  out  1  1 while the state is not STOPPED
- cur_div  out  CNT_W  ratio currently in effect

Behaviour:
- Reset values (rst=0 at a clk edge): state STOPPED, cnt=0, cur_div=DEF_DIV, pend=0, cfg_ready=1, cfg_err=0, clk_out=0, tick=0, busy=0.
- Reset mid-operation takes effect at that edge; the output stops without completing the period. Any pending ratio is lost.
- All outputs are registered.
- Waveform for ratio N:
  - cnt runs 0..N-1.
  - clk_out=1 while cnt < floor(N/2); otherwise clk_out=0. High time is floor(N/2), low time is ceil(N/2).
  - tick=1 exactly when cnt=0 in state RUN.
- States:
  - STOPPED:
    - clk_out=0, tick=0, cnt held at 0.
    - If run=1 at an edge: go to RUN, cnt=0, clk_out=1, tick=1. The first period starts in the cycle after run is sampled.
  - RUN:
    - If cnt != cur_div-1: cnt increments.
    - Boundary (cnt == cur_div-1):
      - If pend=1, cur_div <= the pending ratio and pend clears.
      - If run=1, cnt wraps to 0 and tick is asserted.
      - If run=0, go to STOPPED with clk_out=0. A run deassertion always finishes the current period.
- Handshake:
  - A transfer occurs at an edge where cfg_valid=1 and cfg_ready=1.
  - cfg_ready = !pend, registered. One ratio may be outstanding.
  - Legal N is 2..2^CNT_W-1. N=0 or N=1 completes the handshake, raises cfg_err for exactly one cycle after the transfer, and changes nothing else.
  - Legal N in STOPPED: cur_div updates at the transfer edge; cfg_ready stays 1.
  - Legal N in RUN, transfer edge not a boundary: the ratio is stored as pending, pend=1, cfg_ready=0 until the boundary edge. cfg_ready returns to 1 the cycle after that edge.
  - Legal N in RUN, transfer edge is a boundary: the new ratio applies directly to the period starting at that edge; pend remains 0.
  - Boundary with run=0 while pend=1: the pending ratio is applied, then the block enters STOPPED.
- cnt compares use CNT_W-bit unsigned arithmetic. No value of cnt ever reaches cur_div.
- run toggling inside a period has no effect except the value sampled at the boundary.

Optional Feature:
- Macro: CLKDIV_SCHED_SWCNT_EN.
- Defined: adds output port switch_cnt (8 bits).
  - Reset value 0.
  - Increments by 1 each time a legal ratio actually changes cur_div, whether in STOPPED, at a boundary, or by direct apply.
  - Saturates at 255. Illegal ratios do not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run=1 with DEF_DIV=4:
  - tick every 4 cycles.
  - clk_out pattern 1,1,0,0 repeating.
  - busy=1 and cur_div=4.
- Odd ratio: in STOPPED, write N=5, then run=1:
  - clk_out pattern 1,1,0,0,0.
  - tick period 5.
  - cfg_err stays 0.
- Mid-period switch: running at N=4, write N=6 when cnt=1:
  - cfg_ready=0 until the boundary.
  - Current period completes with 4 cycles; the next period is 6 cycles (1,1,1,0,0,0).
  - cur_div changes to 6 at the boundary edge.
- Boundary-coincident write: running at N=4, write N=2 at the edge where cnt=3:
  - The next period is already 2 cycles.
  - cfg_ready never drops.
- Illegal ratio: write N=1, then N=0:
  - Each transfer gives a one-cycle cfg_err.
  - cur_div and the output waveform are unchanged.
- Stop and reset:
  - Drop run at cnt=1 of N=4: the period finishes (2 more cycles), then busy=0 and clk_out=0.
  - Assert rst=0 mid-period with a ratio pending: all outputs return to reset values at that edge and cur_div=DEF_DIV.
  - With CLKDIV_SCHED_SWCNT_EN defined: after 3 legal switches switch_cnt=3, and it reads 0 after reset.
